// File: rtl/axis_dma_engine.sv
// DMA-side sequencer for a burst-oriented stream accelerator: replays a host-loaded TX buffer
// as one AXI4-Stream burst (MM2S) and captures the return burst into an RX buffer (S2MM).
module axis_dma_engine #(
  parameter int DATA_W     = 32,
  parameter int BURST_LEN  = 32,
  parameter int ADDR_W     = 5,
  parameter int GAP_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_tx,
  input  logic              start_rx,
  input  logic              tx_wr_en,
  input  logic [ADDR_W-1:0] tx_wr_addr,
  input  logic [DATA_W-1:0] tx_wr_data,
  input  logic [ADDR_W-1:0] rx_rd_addr,
  output logic [DATA_W-1:0] rx_rd_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_tlast,
  input  logic              m_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_tlast,
  output logic              s_ready,
  output logic              dma_valid,
  output logic [1:0]        command,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Handshake: a beat moves on a rising edge where valid && ready; the master holds
  // data/tlast stable while valid && !ready and never drops valid before acceptance.

  localparam int CNT_W = ADDR_W + 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  LAST     = CNT_W'(BURST_LEN - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [ADDR_W-1:0] FIRST    = '0;

  typedef enum logic [1:0] {IDLE, TX, RX, GAP} state_t;
  state_t state, state_nxt;

  logic [DATA_W-1:0] tx_buf [2**ADDR_W];
  logic [DATA_W-1:0] rx_buf [2**ADDR_W];
  logic [CNT_W-1:0]  cnt, cnt_inc;
  logic [GAP_W-1:0]  gap_cnt;
  logic tx_fire, rx_fire, cnt_last, go_tx, go_rx, tx_end, rx_end, gap_end;

  always_comb begin
    tx_fire  = m_valid && m_ready;
    rx_fire  = s_valid && s_ready;
    cnt_inc  = cnt + CNT_W'(1);
    cnt_last = (cnt == LAST);
    go_tx    = (state == IDLE) && start_tx;
    go_rx    = (state == IDLE) && start_rx && !start_tx;
    tx_end   = (state == TX) && tx_fire && cnt_last;
    rx_end   = (state == RX) && rx_fire && (s_tlast || cnt_last);
    gap_end  = (state == GAP) && (gap_cnt == GAP_LAST);
    busy     = (state != IDLE);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (go_tx)      state_nxt = TX;
        else if (go_rx) state_nxt = RX;
      end
      TX:      if (tx_end)  state_nxt = GAP;
      RX:      if (rx_end)  state_nxt = GAP;
      GAP:     if (gap_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Buffers are never cleared; the TX buffer is frozen while it is being streamed out.
  always_ff @(posedge clk) begin
    if (tx_wr_en && state != TX) tx_buf[tx_wr_addr] <= tx_wr_data;
    if (rst && state == RX && rx_fire) rx_buf[cnt[ADDR_W-1:0]] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_rd_data <= '0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      m_tlast    <= 1'b0;
      s_ready    <= 1'b0;
      dma_valid  <= 1'b0;
      command    <= 2'd0;
      done       <= 1'b0;
      err        <= 1'b0;
      cnt        <= '0;
      gap_cnt    <= '0;
    end else begin
      done       <= 1'b0;
      rx_rd_data <= rx_buf[rx_rd_addr];
      case (state)
        IDLE: begin
          dma_valid <= 1'b1;
          if (go_tx) begin
            m_valid <= 1'b1;
            m_data  <= tx_buf[FIRST];
            m_tlast <= 1'b0;
            command <= 2'd1;
            cnt     <= '0;
            err     <= 1'b0;
          end else if (go_rx) begin
            s_ready <= 1'b1;
            command <= 2'd2;
            cnt     <= '0;
            err     <= 1'b0;
          end
        end
        TX: begin
          if (tx_fire) begin
            command <= 2'd0;
            if (cnt_last) begin
              m_valid   <= 1'b0;
              m_tlast   <= 1'b0;
              dma_valid <= 1'b0;
              gap_cnt   <= '0;
            end else begin
              cnt     <= cnt_inc;
              m_data  <= tx_buf[cnt_inc[ADDR_W-1:0]];
              m_tlast <= (cnt_inc == LAST);
            end
          end
        end
        RX: begin
          if (rx_fire) begin
            command <= 2'd0;
            // Early tlast and missing tlast both end the burst and flag it.
            if (s_tlast != cnt_last) err <= 1'b1;
            if (s_tlast || cnt_last) begin
              s_ready   <= 1'b0;
              dma_valid <= 1'b0;
              gap_cnt   <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        GAP: begin
          if (gap_end) begin
            dma_valid <= 1'b1;
            done      <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_dma_engine.sv
// Directed bench for axis_dma_engine: TX replay, backpressure, RX capture, tlast errors,
// loopback, start priority and mid-burst reset.
`timescale 1ns/1ps
module tb_axis_dma_engine;
  localparam int DW = 32, BL = 32, AW = 5, GAP = 4;

  logic          clk = 1'b0, rst = 1'b0;
  logic          start_tx, start_rx, tx_wr_en;
  logic [AW-1:0] tx_wr_addr, rx_rd_addr;
  logic [DW-1:0] tx_wr_data, rx_rd_data, m_data, s_data;
  logic          m_valid, m_tlast, m_ready, s_valid, s_tlast, s_ready;
  logic          dma_valid, busy, done, err;
  logic [1:0]    command;

  int total = 0, bad = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] txw[BL], src[BL], exp_rx[BL], cap[BL];

  always #5 clk = ~clk;

  axis_dma_engine #(.DATA_W(DW), .BURST_LEN(BL), .ADDR_W(AW), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .start_tx(start_tx), .start_rx(start_rx),
    .tx_wr_en(tx_wr_en), .tx_wr_addr(tx_wr_addr), .tx_wr_data(tx_wr_data),
    .rx_rd_addr(rx_rd_addr), .rx_rd_data(rx_rd_data),
    .m_data(m_data), .m_valid(m_valid), .m_tlast(m_tlast), .m_ready(m_ready),
    .s_data(s_data), .s_valid(s_valid), .s_tlast(s_tlast), .s_ready(s_ready),
    .dma_valid(dma_valid), .command(command), .busy(busy), .done(done), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load_tx();
    for (int i = 0; i < BL; i++) begin
      tx_wr_en = 1'b1; tx_wr_addr = AW'(i); tx_wr_data = txw[i];
      tick();
    end
    tx_wr_en = 1'b0;
  endtask

  task automatic wait_gap();
    int gap;
    gap = 0;
    while (dma_valid == 1'b0 && gap < 20) begin
      check("gap_done", done, 0);
      check("gap_busy", busy, 1);
      gap++;
      tick();
    end
    check("gap_len", gap, GAP);
    check("done_rise", done, 1);
    check("busy_fall", busy, 0);
    check("dma_valid_rise", dma_valid, 1);
    tick();
    check("done_pulse", done, 0);
  endtask

  // mode 0: m_ready held high; mode 1: m_ready toggles starting low
  task automatic tx_burst(input int mode, input int exp_cyc);
    int cyc, acc;
    exp_q.delete();
    for (int i = 0; i < BL; i++) exp_q.push_back(txw[i]);
    start_tx = 1'b1; tick(); start_tx = 1'b0;
    check("tx_start_err", err, 0);
    cyc = 0; acc = 0;
    while (exp_q.size() > 0 && cyc < 200) begin
      check("tx_valid", m_valid, 1);
      check("tx_data", m_data, exp_q[0]);
      check("tx_tlast", m_tlast, exp_q.size() == 1);
      check("tx_cmd", command, (acc == 0) ? 1 : 0);
      check("tx_sready", s_ready, 0);
      start_rx   = (cyc == 5);
      tx_wr_en   = (cyc == 3);
      tx_wr_addr = AW'(BL - 1);
      tx_wr_data = 32'hDEAD_BEEF;
      m_ready    = (mode == 0) ? 1'b1 : cyc[0];
      if (m_ready) begin
        cap[acc] = m_data;
        acc++;
        void'(exp_q.pop_front());
      end
      cyc++;
      tick();
    end
    m_ready = 1'b0; start_rx = 1'b0; tx_wr_en = 1'b0;
    check("tx_cycles", cyc, exp_cyc);
    check("tx_valid_drop", m_valid, 0);
    check("tx_tlast_drop", m_tlast, 0);
    check("tx_busy", busy, 1);
    wait_gap();
  endtask

  task automatic rx_burst(input int n, input int tl, input bit chk0,
                          input logic [31:0] old0, input bit exp_err);
    int k;
    rx_rd_addr = '0;
    start_rx = 1'b1; tick(); start_rx = 1'b0;
    check("rx_cmd0", command, 2);
    check("rx_ready0", s_ready, 1);
    check("rx_mvalid", m_valid, 0);
    check("rx_err0", err, 0);
    k = 0;
    for (int c = 0; c < 100 && k < n; c++) begin
      check("rx_ready", s_ready, 1);
      check("rx_cmd", command, (k == 0) ? 2 : 0);
      if (chk0 && c == 1) check("rx_rd_old", rx_rd_data, old0);
      if (chk0 && c == 2) check("rx_rd_new", rx_rd_data, src[0]);
      if (c == 5) begin
        s_valid = 1'b0;
      end else begin
        s_valid = 1'b1; s_data = src[k]; s_tlast = (k == tl);
        k++;
      end
      tick();
    end
    s_valid = 1'b0; s_tlast = 1'b0;
    check("rx_ready_drop", s_ready, 0);
    wait_gap();
    check("rx_err", err, exp_err);
  endtask

  task automatic read_rx(input int n);
    for (int i = 0; i < n; i++) begin
      rx_rd_addr = AW'(i);
      tick();
      check("rx_rd", rx_rd_data, exp_rx[i]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    start_tx = 0; start_rx = 0; tx_wr_en = 0; tx_wr_addr = '0; tx_wr_data = '0;
    rx_rd_addr = '0; m_ready = 0; s_data = '0; s_valid = 0; s_tlast = 0;
    tick(); tick();
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_dma_valid", dma_valid, 0);
    check("rst_command", command, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rx_rd", rx_rd_data, 0);
    rst = 1'b1;
    check("release_dma_low", dma_valid, 0);
    tick();
    check("release_dma_up", dma_valid, 1);
    check("release_busy", busy, 0);

    // T1: plain TX, words 100..131
    for (int i = 0; i < BL; i++) txw[i] = 32'(100 + i);
    load_tx();
    tx_burst(0, 32);
    // T2: backpressure, same buffer, one beat per two cycles
    tx_burst(1, 64);

    // T3: clean RX burst
    for (int i = 0; i < BL; i++) begin src[i] = 32'h0A0 + 32'(i); exp_rx[i] = src[i]; end
    rx_burst(32, 31, 1'b0, 32'h0, 1'b0);
    read_rx(32);
    // full-length burst with no tlast
    for (int i = 0; i < BL; i++) begin src[i] = 32'h0B0 + 32'(i); exp_rx[i] = src[i]; end
    rx_burst(32, 99, 1'b0, 32'h0, 1'b1);
    read_rx(32);
    // T4: tlast at beat 9, words 10+ keep the previous burst
    for (int i = 0; i < 10; i++) begin src[i] = 32'h0C0 + 32'(i); exp_rx[i] = src[i]; end
    rx_burst(10, 9, 1'b1, 32'h0B0, 1'b1);
    read_rx(12);

    // T5: loopback, TX capture fed back as RX stream
    for (int i = 0; i < BL; i++) txw[i] = 32'h1234_0000 + 32'(i) * 32'h0101 + 32'h5A;
    load_tx();
    tx_burst(0, 32);
    for (int i = 0; i < BL; i++) begin src[i] = cap[i]; exp_rx[i] = txw[i]; end
    rx_burst(32, 31, 1'b0, 32'h0, 1'b0);
    read_rx(32);

    // T6: simultaneous starts pick TX, then reset at beat 15
    start_tx = 1'b1; start_rx = 1'b1; tick(); start_tx = 1'b0; start_rx = 1'b0;
    check("both_cmd", command, 1);
    check("both_mvalid", m_valid, 1);
    check("both_sready", s_ready, 0);
    for (int b = 0; b < 15; b++) begin
      check("t6_data", m_data, txw[b]);
      m_ready = 1'b1;
      tick();
    end
    check("t6_beat15", m_data, txw[15]);
    rst = 1'b0; m_ready = 1'b0;
    tick();
    check("mid_rst_mvalid", m_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_dma", dma_valid, 0);
    check("mid_rst_cmd", command, 0);
    check("mid_rst_done", done, 0);
    rst = 1'b1;
    tick();
    check("mid_rst_dma_up", dma_valid, 1);
    tx_burst(0, 32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
